rc4_phase_sequencer: RTL and testbench

//  Top-level controller for the RC4 key search. Runs init -> shuffle -> decrypt for each candidate
//  key using start/done handshakes, and owns the single S-memory port by granting it to the active

---
 rtl/rc4_phase_sequencer.sv | 167 ++++++++++++++++
 tb/tb_rc4_phase_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rc4_phase_sequencer.sv
// Top-level RC4 key-search controller: steps candidate keys through the init -> shuffle -> decrypt
// phases with start/done handshakes and grants the single S-memory port to the active phase.
module rc4_phase_sequencer #(
  parameter int                KEY_W     = 24,
  parameter logic [KEY_W-1:0]  KEY_FIRST = '0,
  parameter logic [KEY_W-1:0]  KEY_LAST  = 24'h3FFFFF,
  parameter int                TIMEOUT   = 4096
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              init_start,
  input  logic              init_done,
  output logic              shuf_start,
  input  logic              shuf_done,
  output logic              dec_start,
  input  logic              dec_done,
  input  logic              dec_success,
  input  logic [23:0]       req_data,
  input  logic [23:0]       req_addr,
  input  logic [2:0]        req_wren,
  input  logic [2:0]        req_rden,
  output logic [7:0]        mem_data,
  output logic [7:0]        mem_addr,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [KEY_W-1:0]  secret_key,
  output logic [1:0]        phase,
  output logic              busy,
  output logic              found,
  output logic              exhausted,
  output logic              timeout_err
);

  localparam int   TMR_W       = $clog2(TIMEOUT + 1);
  // An inverted key range still gets exactly one attempt before giving up.
  localparam logic SINGLE_SHOT = (KEY_FIRST > KEY_LAST);

  typedef enum logic [3:0] {
    S_IDLE, S_INIT_GO, S_INIT_RUN, S_SHUF_GO, S_SHUF_RUN,
    S_DEC_GO, S_DEC_RUN, S_FOUND, S_EXHAUST, S_ERROR
  } state_e;

  state_e            state_q, state_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic [TMR_W-1:0]  timer_inc;
  logic              timer_expired;

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      key_q   <= KEY_FIRST;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      timer_q <= timer_d;
    end
  end

  assign timer_inc     = timer_q + TMR_W'(1);
  assign timer_expired = (timer_inc == TMR_W'(TIMEOUT));

  // NOTE: every signal written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    timer_d = timer_q;
    unique case (state_q)
      S_IDLE, S_FOUND, S_EXHAUST, S_ERROR: begin
        if (start) begin
          state_d = S_INIT_GO;
          key_d   = KEY_FIRST;
        end
      end
      S_INIT_GO: begin
        state_d = S_INIT_RUN;
        timer_d = '0;
      end
      S_INIT_RUN: begin
        timer_d = timer_inc;
        if (init_done)          state_d = S_SHUF_GO;
        else if (timer_expired) state_d = S_ERROR;
      end
      S_SHUF_GO: begin
        state_d = S_SHUF_RUN;
        timer_d = '0;
      end
      S_SHUF_RUN: begin
        timer_d = timer_inc;
        if (shuf_done)          state_d = S_DEC_GO;
        else if (timer_expired) state_d = S_ERROR;
      end
      S_DEC_GO: begin
        state_d = S_DEC_RUN;
        timer_d = '0;
      end
      S_DEC_RUN: begin
        timer_d = timer_inc;
        if (dec_done) begin
          if (dec_success) begin
            state_d = S_FOUND;
          end else if (SINGLE_SHOT || key_q == KEY_LAST) begin
            state_d = S_EXHAUST;
          end else begin
            state_d = S_INIT_GO;
            key_d   = key_q + KEY_W'(1);
          end
        end else if (timer_expired) begin
          state_d = S_ERROR;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase and memory grant are pure decodes of the registered state.
  always_comb begin
    phase = 2'd0;
    unique case (state_q)
      S_INIT_GO, S_INIT_RUN: phase = 2'd1;
      S_SHUF_GO, S_SHUF_RUN: phase = 2'd2;
      S_DEC_GO,  S_DEC_RUN:  phase = 2'd3;
      default:               phase = 2'd0;
    endcase
  end

  always_comb begin
    mem_data = 8'h00;
    mem_addr = 8'h00;
    mem_wren = 1'b0;
    mem_rden = 1'b0;
    unique case (phase)
      2'd1: begin
        mem_data = req_data[7:0];
        mem_addr = req_addr[7:0];
        mem_wren = req_wren[0];
        mem_rden = req_rden[0];
      end
      2'd2: begin
        mem_data = req_data[15:8];
        mem_addr = req_addr[15:8];
        mem_wren = req_wren[1];
        mem_rden = req_rden[1];
      end
      2'd3: begin
        mem_data = req_data[23:16];
        mem_addr = req_addr[23:16];
        mem_wren = req_wren[2];
        mem_rden = req_rden[2];
      end
      default: ;
    endcase
  end

  assign init_start  = (state_q == S_INIT_GO);
  assign shuf_start  = (state_q == S_SHUF_GO);
  assign dec_start   = (state_q == S_DEC_GO);
  assign busy        = (phase != 2'd0);
  assign found       = (state_q == S_FOUND);
  assign exhausted   = (state_q == S_EXHAUST);
  assign timeout_err = (state_q == S_ERROR);
  assign secret_key  = key_q;

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Self-checking bench for rc4_phase_sequencer: the bench plays the three phase FSMs and predicts
// every cycle's handshake, key, flags and memory grant from the search rules.
module tb_rc4_phase_sequencer;

  localparam int          KEY_W     = 24;
  localparam logic [23:0] KEY_FIRST = 24'h000000;
  localparam logic [23:0] KEY_LAST  = 24'h000003;
  localparam int          TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        init_done, shuf_done, dec_done, dec_success;
  logic [23:0] req_data, req_addr;
  logic [2:0]  req_wren, req_rden;
  logic        init_start, shuf_start, dec_start;
  logic [7:0]  mem_data, mem_addr;
  logic        mem_wren, mem_rden;
  logic [23:0] secret_key;
  logic [1:0]  phase;
  logic        busy, found, exhausted, timeout_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit fixed_req = 1'b0;

  rc4_phase_sequencer #(
    .KEY_W(KEY_W), .KEY_FIRST(KEY_FIRST), .KEY_LAST(KEY_LAST), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .init_start(init_start), .init_done(init_done),
    .shuf_start(shuf_start), .shuf_done(shuf_done),
    .dec_start(dec_start), .dec_done(dec_done), .dec_success(dec_success),
    .req_data(req_data), .req_addr(req_addr), .req_wren(req_wren), .req_rden(req_rden),
    .mem_data(mem_data), .mem_addr(mem_addr), .mem_wren(mem_wren), .mem_rden(mem_rden),
    .secret_key(secret_key), .phase(phase), .busy(busy),
    .found(found), .exhausted(exhausted), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_handshakes();
    start     = 1'b0;
    init_done = 1'b0;
    shuf_done = 1'b0;
    dec_done  = 1'b0;
    dec_success = 1'($urandom);
  endtask

  // Spurious activity: done of the non-active phases, start while busy, and (in a GO cycle)
  // the active phase's own done, all of which the sequencer must ignore.
  task automatic drive_noise(input int p, input bit own);
    start       = 1'($urandom);
    init_done   = (p != 0 || own) ? 1'($urandom) : 1'b0;
    shuf_done   = (p != 1 || own) ? 1'($urandom) : 1'b0;
    dec_done    = (p != 2 || own) ? 1'($urandom) : 1'b0;
    dec_success = 1'($urandom);
  endtask

  // ph: expected phase output (0 none); pulse: which start pulse is expected (-1 none);
  // flag: 0 none, 1 found, 2 exhausted, 3 timeout.
  task automatic expect_cycle(input int ph, input int pulse, input logic [23:0] key, input int flag);
    logic [7:0] e_data, e_addr;
    logic       e_wren, e_rden;
    int         p;
    check("phase",       32'(phase),       32'(ph));
    check("busy",        32'(busy),        32'(ph != 0));
    check("init_start",  32'(init_start),  32'(pulse == 0));
    check("shuf_start",  32'(shuf_start),  32'(pulse == 1));
    check("dec_start",   32'(dec_start),   32'(pulse == 2));
    check("secret_key",  32'(secret_key),  32'(key));
    check("found",       32'(found),       32'(flag == 1));
    check("exhausted",   32'(exhausted),   32'(flag == 2));
    check("timeout_err", 32'(timeout_err), 32'(flag == 3));
    req_data = 24'($urandom);
    req_addr = fixed_req ? 24'h332211 : 24'($urandom);
    req_wren = fixed_req ? 3'b111 : 3'($urandom);
    req_rden = 3'($urandom);
    #1;
    e_data = 8'h00; e_addr = 8'h00; e_wren = 1'b0; e_rden = 1'b0;
    if (ph != 0) begin
      p      = ph - 1;
      e_data = req_data[8*p +: 8];
      e_addr = req_addr[8*p +: 8];
      e_wren = req_wren[p];
      e_rden = req_rden[p];
    end
    check("mem_data", 32'(mem_data), 32'(e_data));
    check("mem_addr", 32'(mem_addr), 32'(e_addr));
    check("mem_wren", 32'(mem_wren), 32'(e_wren));
    check("mem_rden", 32'(mem_rden), 32'(e_rden));
  endtask

  // Entered in the GO cycle of phase p. Checks GO plus `delay` RUN cycles, then (unless hold)
  // raises the phase's done in the last RUN cycle and steps into the following state.
  task automatic do_phase(input int p, input int delay, input bit succ, input bit hold,
                          input bit noise, input logic [23:0] key);
    expect_cycle(p + 1, p, key, 0);
    for (int i = 0; i < delay; i++) begin
      if (noise) drive_noise(p, i == 0);
      step();
      clear_handshakes();
      expect_cycle(p + 1, -1, key, 0);
    end
    if (!hold) begin
      case (p)
        0:       init_done = 1'b1;
        1:       shuf_done = 1'b1;
        default: begin dec_done = 1'b1; dec_success = succ; end
      endcase
      step();
      clear_handshakes();
    end
  endtask

  function automatic int pick_delay(input int fixed);
    return (fixed > 0) ? fixed : int'($urandom_range(1, TIMEOUT));
  endfunction

  task automatic attempt(input logic [23:0] key, input int fixed, input bit succ, input bit noise);
    do_phase(0, pick_delay(fixed), 1'b0, 1'b0, noise, key);
    do_phase(1, pick_delay(fixed), 1'b0, 1'b0, noise, key);
    do_phase(2, pick_delay(fixed), succ, 1'b0, noise, key);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Whole search: keys KEY_FIRST..KEY_LAST in order, success on key succ_at (none if beyond range).
  task automatic search(input int succ_at, input int fixed, input bit noise);
    int last_key;
    pulse_start();
    last_key = int'(KEY_LAST);
    for (int k = int'(KEY_FIRST); k <= int'(KEY_LAST); k++) begin
      attempt(24'(k), fixed, k == succ_at, noise);
      if (k == succ_at) begin
        last_key = k;
        break;
      end
    end
    for (int i = 0; i < 3; i++) begin
      expect_cycle(0, -1, 24'(last_key), (succ_at <= int'(KEY_LAST)) ? 1 : 2);
      step();
    end
  endtask

  initial begin
    reset = 1'b0;
    req_data = '0; req_addr = '0; req_wren = '0; req_rden = '0;
    clear_handshakes();

    // Reset state, including start asserted under reset.
    start = 1'b1;
    step();
    expect_cycle(0, -1, KEY_FIRST, 0);
    step();
    start = 1'b0;
    reset = 1'b1;
    expect_cycle(0, -1, KEY_FIRST, 0);
    step();
    expect_cycle(0, -1, KEY_FIRST, 0);

    // Each done 5 cycles after its start, success on the first key; fixed per-phase addresses.
    fixed_req = 1'b1;
    search(0, 5, 1'b0);
    fixed_req = 1'b0;

    // No success anywhere: keys 0..3 in order, then exhausted with the last key held.
    search(int'(KEY_LAST) + 1, 0, 1'b0);

    // Shuffle never finishes: busy for TIMEOUT run cycles, then error with the grant released.
    pulse_start();
    do_phase(0, 3, 1'b0, 1'b0, 1'b0, KEY_FIRST);
    do_phase(1, TIMEOUT, 1'b0, 1'b1, 1'b0, KEY_FIRST);
    step();
    expect_cycle(0, -1, KEY_FIRST, 3);
    step();
    expect_cycle(0, -1, KEY_FIRST, 3);

    // Restart from the error state, with done pulses arriving on the last legal run cycle.
    search(1, TIMEOUT, 1'b0);

    // Randomized searches with spurious done/start pulses in every phase.
    for (int n = 0; n < 6; n++) begin
      search(int'($urandom_range(0, 4)), 0, 1'b1);
    end

    // Reset in the middle of decrypt for key 2 returns straight to idle.
    pulse_start();
    attempt(24'd0, 0, 1'b0, 1'b1);
    attempt(24'd1, 0, 1'b0, 1'b1);
    do_phase(0, 2, 1'b0, 1'b0, 1'b0, 24'd2);
    do_phase(1, 2, 1'b0, 1'b0, 1'b0, 24'd2);
    do_phase(2, 3, 1'b0, 1'b1, 1'b0, 24'd2);
    reset    = 1'b0;
    dec_done = 1'b1;
    dec_success = 1'b1;
    step();
    clear_handshakes();
    expect_cycle(0, -1, KEY_FIRST, 0);
    reset = 1'b1;
    step();
    expect_cycle(0, -1, KEY_FIRST, 0);
    search(2, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
